// File: rtl/pmod_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : pmod_bus_master
// Purpose  : Turns decoded Pmod read/write requests into 64-bit burst-bus
//            transactions, with write/read beat FIFOs between the two sides.
//            Optional watchdog: define PMOD_BUS_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pmod_bus_master #(
   parameter int WFIFO_DEPTH = 4,
   parameter int RFIFO_DEPTH = 4,
   parameter int TIMEOUT     = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        write_req,
   input  logic        write_bus_req,
   input  logic        read_req,
   input  logic [9:0]  len,
   input  logic [31:0] address,
   input  logic [63:0] wdata,
   output logic        busy,
   output logic [63:0] rdata,
   output logic        rlast,
   input  logic        rnext,
   output logic        m_cmd_valid,
   input  logic        m_cmd_ready,
   output logic        m_cmd_we,
   output logic [31:0] m_cmd_addr,
   output logic [7:0]  m_cmd_beats,
   output logic [63:0] m_wdata,
   output logic [7:0]  m_wstrb,
   output logic        m_wvalid,
   input  logic        m_wready,
   output logic        m_wlast,
   input  logic        m_done,
   input  logic [63:0] m_rdata,
   input  logic        m_rvalid,
   input  logic        m_rlast,
   output logic        m_rready
);
   localparam int c_waw = $clog2(WFIFO_DEPTH);
   localparam int c_raw = $clog2(RFIFO_DEPTH);
   localparam logic [c_waw:0] c_wptr_one = (c_waw+1)'(1);
   localparam logic [c_raw:0] c_rptr_one = (c_raw+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WCMD    = 3'd1,
      S_WSTREAM = 3'd2,
      S_WDONE   = 3'd3,
      S_RCMD    = 3'd4,
      S_RSTREAM = 3'd5
   } state_t;

   state_t r_state, w_next_state;

   logic [9:0]             r_len;
   logic [31:0]            r_addr;
   logic [7:0]             r_wcnt;
   logic [63:0]            r_wmem [WFIFO_DEPTH];
   logic [c_waw:0]         r_wrp, r_wwp;
   logic [63:0]            r_rmem [RFIFO_DEPTH];
   logic [RFIFO_DEPTH-1:0] r_rtag;
   logic [c_raw:0]         r_rrp, r_rwp;

   logic        w_wempty, w_wfull, w_rempty, w_rfull;
   logic        w_single, w_wlast_beat;
   logic [7:0]  w_beats_m1, w_strb;
   logic [3:0]  w_bytes;
   logic [15:0] w_strb_wide;
   logic        w_wpush_req, w_wpush, w_wpop, w_wflush;
   logic        w_latch, w_rflush, w_rpush, w_rpop, w_rpush_last;
   logic [63:0] w_rpush_data;
   logic        w_wdt_expire;
   logic        w_unused;

   // write_bus_req is implied by the beat count; the upper strobe bits are the discarded carry
   assign w_unused = ^{write_bus_req, w_strb_wide[15:8], (TIMEOUT == 0)};

   assign w_wempty = (r_wrp == r_wwp);
   assign w_wfull  = (r_wrp[c_waw] != r_wwp[c_waw]) && (r_wrp[c_waw-1:0] == r_wwp[c_waw-1:0]);
   assign w_rempty = (r_rrp == r_rwp);
   assign w_rfull  = (r_rrp[c_raw] != r_rwp[c_raw]) && (r_rrp[c_raw-1:0] == r_rwp[c_raw-1:0]);

   assign w_single   = |r_len[2:0];
   assign w_beats_m1 = w_single ? 8'd0 : {1'b0, r_len[9:3]};

   always_comb begin
      w_bytes = 4'd8;
      if (r_len[2:0] == 3'b001)      w_bytes = 4'd1;
      else if (r_len[2:0] == 3'b010) w_bytes = 4'd2;
      else if (r_len[2:0] == 3'b100) w_bytes = 4'd4;
   end

   assign w_strb_wide  = ((16'd1 << w_bytes) - 16'd1) << r_addr[2:0];
   assign w_strb       = w_single ? w_strb_wide[7:0] : 8'hFF;
   assign w_wlast_beat = (r_wcnt == w_beats_m1);

   assign m_cmd_valid = (r_state == S_WCMD) || (r_state == S_RCMD);
   assign m_cmd_we    = (r_state == S_WCMD);
   assign m_cmd_addr  = {r_addr[31:3], 3'b000};
   assign m_cmd_beats = w_beats_m1;
   assign m_wvalid    = (r_state == S_WSTREAM) && !w_wempty;
   assign m_wdata     = m_wvalid ? r_wmem[r_wrp[c_waw-1:0]] : 64'd0;
   assign m_wstrb     = m_wvalid ? w_strb : 8'd0;
   assign m_wlast     = m_wvalid && w_wlast_beat;
   assign m_rready    = (r_state == S_RSTREAM) && !w_rfull;

   assign rdata = w_rempty ? 64'd0 : r_rmem[r_rrp[c_raw-1:0]];
   assign rlast = !w_rempty && r_rtag[r_rrp[c_raw-1:0]];
   assign busy  = (r_state == S_WCMD) || (r_state == S_WSTREAM) || (r_state == S_WDONE) ||
                  (r_state == S_RCMD) || ((r_state == S_RSTREAM) && w_rempty);

   assign w_wpush_req = write_req &&
                        ((r_state == S_IDLE) || (r_state == S_WCMD) || (r_state == S_WSTREAM));
   assign w_wpush     = w_wpush_req && !w_wfull;
   assign w_rpop      = rnext && !w_rempty;

`ifdef PMOD_BUS_WDT_EN
   localparam int c_wdw = $clog2(TIMEOUT + 1);
   localparam logic [c_wdw-1:0] c_wdt_one = c_wdw'(1);
   logic [c_wdw-1:0] r_wdt;
   logic             w_handshake;

   assign w_handshake  = (m_cmd_valid && m_cmd_ready) || (m_wvalid && m_wready) ||
                         (m_rvalid && m_rready) || ((r_state == S_WDONE) && m_done);
   assign w_wdt_expire = (r_state != S_IDLE) && !w_handshake && (r_wdt == c_wdw'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_wdt <= '0;
      else if ((r_state == S_IDLE) || w_handshake || w_wdt_expire)
         r_wdt <= '0;
      else
         r_wdt <= r_wdt + c_wdt_one;
   end
`else
   assign w_wdt_expire = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      w_latch      = 1'b0;
      w_rflush     = 1'b0;
      w_wflush     = 1'b0;
      w_wpop       = 1'b0;
      w_rpush      = 1'b0;
      w_rpush_data = m_rdata;
      w_rpush_last = m_rlast;
      case (r_state)
         S_IDLE: begin
            // a coincident read_req is dropped: write has priority
            if (write_req) begin
               w_latch      = 1'b1;
               w_next_state = S_WCMD;
            end else if (read_req) begin
               w_latch      = 1'b1;
               w_rflush     = 1'b1;
               w_next_state = S_RCMD;
            end
         end
         S_WCMD:    if (m_cmd_ready) w_next_state = S_WSTREAM;
         S_WSTREAM: begin
            if (m_wvalid && m_wready) begin
               w_wpop = 1'b1;
               if (w_wlast_beat) w_next_state = S_WDONE;
            end
         end
         S_WDONE:   if (m_done) w_next_state = S_IDLE;
         S_RCMD:    if (m_cmd_ready) w_next_state = S_RSTREAM;
         S_RSTREAM: begin
            if (m_rvalid && m_rready) begin
               w_rpush = 1'b1;
               if (m_rlast) w_next_state = S_IDLE;
            end
         end
         default:   w_next_state = S_IDLE;
      endcase
      if (w_wdt_expire) begin
         w_next_state = S_IDLE;
         if ((r_state == S_RCMD) || (r_state == S_RSTREAM)) begin
            w_rpush      = !w_rfull;
            w_rpush_data = '1;
            w_rpush_last = 1'b1;
         end else begin
            w_wflush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_len   <= '0;
         r_addr  <= '0;
         r_wcnt  <= '0;
         r_wrp   <= '0;
         r_wwp   <= '0;
         r_rrp   <= '0;
         r_rwp   <= '0;
         r_rtag  <= '0;
         for (int i = 0; i < WFIFO_DEPTH; i++) r_wmem[i] <= '0;
         for (int i = 0; i < RFIFO_DEPTH; i++) r_rmem[i] <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_latch) begin
            r_len  <= len;
            r_addr <= address;
            r_wcnt <= '0;
         end else if (w_wpop) begin
            r_wcnt <= r_wcnt + 8'd1;
         end
         if (w_wflush) begin
            r_wrp <= '0;
            r_wwp <= '0;
         end else begin
            if (w_wpush) begin
               r_wmem[r_wwp[c_waw-1:0]] <= wdata;
               r_wwp                    <= r_wwp + c_wptr_one;
            end
            if (w_wpop) r_wrp <= r_wrp + c_wptr_one;
         end
         if (w_rflush) begin
            r_rrp <= '0;
            r_rwp <= '0;
         end else begin
            if (w_rpush) begin
               r_rmem[r_rwp[c_raw-1:0]] <= w_rpush_data;
               r_rtag[r_rwp[c_raw-1:0]] <= w_rpush_last;
               r_rwp                    <= r_rwp + c_rptr_one;
            end
            if (w_rpop) r_rrp <= r_rrp + c_rptr_one;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(w_wpush_req && w_wfull))
            else $error("pmod_bus_master: write beat dropped, write FIFO full");
      end
   end

endmodule
`default_nettype wire

// File: doc/pmod_bus_master.md
Name:
pmod_bus_master

Overview:
- Downstream stage of the Pmod command decoder.
- Consumes decoded write and read requests (len, address, 64-bit write beats) and issues transactions on the native 64-bit burst bus toward memory.
- Returns read beats, the last-beat flag and a busy/wait indication to the decoder.
- Buffers write beats and read beats in small FIFOs so the slow Pmod side and the fast bus side are decoupled.

Parameters:
WFIFO_DEPTH, 4, write-beat FIFO entries (power of 2, ≥2)
RFIFO_DEPTH, 4, read-beat FIFO entries (power of 2, ≥2)
TIMEOUT, 1024, watchdog cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
write_req  in  1  one-cycle pulse: wdata holds a complete 64-bit beat
write_bus_req  in  1  one-cycle pulse, coincident with the final write_req of a command
read_req  in  1  one-cycle pulse: start read; len/address valid
len  in  10  decoder length code
address  in  32  byte address
wdata  in  64  write beat (valid only in the write_req cycle)
busy  out  1  read data not yet available / write in progress
rdata  out  64  head read beat
rlast  out  1  head beat is the final beat of the burst
rnext  in  1  pop head read beat (tied low by single-beat consumers)
m_cmd_valid  out  1  command valid
m_cmd_ready  in  1  command accepted
m_cmd_we  out  1  1 = write, 0 = read
m_cmd_addr  out  32  {address[31:3],3'b000}
m_cmd_beats  out  8  beat count minus 1
m_wdata  out  64  write beat
m_wstrb  out  8  byte enables
m_wvalid  out  1  write beat valid
m_wready  in  1  write beat accepted
m_wlast  out  1  final write beat
m_done  in  1  write completion pulse
m_rdata  in  64  read beat
m_rvalid  in  1  read beat valid
m_rlast  in  1  final read beat
m_rready  out  1  read beat accepted

Behaviour:
- Reset (asynchronous): all outputs 0, both FIFOs empty, state IDLE.
- Beat count N:
  - len[2:0]≠000 → N=1.
  - Otherwise N=len[9:3]+1 (1..128).
  - m_cmd_beats=N-1.
- Strobes:
  - N=1: byte count decoded from len[2:0] (001→1, 010→2, 100→4, 11x→8, priority as listed). m_wstrb = ((1<<bytes)-1)<<address[2:0], truncated to 8 bits (no carry into the next beat).
  - Bursts: m_wstrb=8'hFF.
- Command capture: len and address are latched when the command starts.
- FSM states: IDLE, WCMD, WSTREAM, WDONE, RCMD, RSTREAM.
  - IDLE:
    - write_req → push wdata, latch, go WCMD.
    - read_req → flush RFIFO, latch, go RCMD.
    - Both in the same cycle → write wins; read is dropped.
  - WCMD: m_cmd_valid=1, m_cmd_we=1; hold until m_cmd_ready, then WSTREAM.
  - WSTREAM:
    - m_wvalid = WFIFO not empty; pop on m_wvalid&m_wready.
    - m_wlast=1 on beat N-1; after it is popped → WDONE.
  - WDONE: wait for m_done → IDLE.
  - RCMD: m_cmd_valid=1, m_cmd_we=0; on m_cmd_ready → RSTREAM.
  - RSTREAM:
    - m_rready = RFIFO not full.
    - Each accepted beat is pushed with a last tag = m_rlast.
    - After the m_rlast beat is accepted → IDLE.
- write_req beats are pushed in any write state (WCMD/WSTREAM). write_req while WFIFO is full drops the beat; simulation raises $error. read_req outside IDLE is ignored.
- Read data:
  - rdata/rlast = RFIFO head (registered).
  - rnext pops the head; rnext while empty is ignored.
  - Contents stay readable in IDLE until the next read_req flushes them.
- busy=1 when:
  - in WCMD, WSTREAM or WDONE;
  - in RCMD;
  - in RSTREAM with RFIFO empty.
- Latencies:
  - write_req in IDLE → m_cmd_valid the next cycle.
  - m_rvalid&m_rready → rdata valid and busy=0 the next cycle.
  - m_done → busy=0 the next cycle.

Optional Feature:
PMOD_BUS_WDT_EN:
- With the macro: a counter runs in all non-IDLE states and restarts on any handshake (cmd, w, r, done). When it reaches TIMEOUT:
  - write: force IDLE and flush WFIFO;
  - read: push a beat of 64'hFFFF_FFFF_FFFF_FFFF with last=1, then IDLE.
- Without the macro: no counter; the block waits indefinitely.

Test Plan:
- Small write: len=10'h004, address=32'h1000_0006, one write_req+write_bus_req with wdata=64'h0123_4567_89AB_CDEF → m_cmd_addr=32'h1000_0000, m_cmd_beats=0, m_wstrb=8'hC0, m_wlast=1; busy drops the cycle after m_done.
- Burst write: len=10'h018, four write_req pulses 40 cycles apart (last with write_bus_req) → m_cmd_beats=3, four beats in order with m_wstrb=8'hFF, m_wlast only on the 4th.
- Read: len=10'h006, address=32'h2000_0008, m_rvalid delayed 10 cycles → busy=1 throughout, rdata=m_rdata and rlast=1 the cycle after the beat; busy=0.
- Backpressure: m_cmd_ready low 20 cycles, m_wready alternating 1/0 during an 8-beat write → no lost or duplicated beats, order preserved, exactly one m_wlast.
- Reset asserted mid-burst (beat 2 of 4) → all outputs 0 asynchronously; a following 1-beat read completes normally.
- Watchdog: with PMOD_BUS_WDT_EN and TIMEOUT=256, m_cmd_ready held 0 on a read → after 256 cycles rdata=all-ones, rlast=1, busy=0. Without the macro, busy stays 1.
